// File: rtl/rf_pkg.sv
// Shared constants and state encoding for the register-file write-port arbiter.
package rf_pkg;

    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int NREG = 32;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    localparam logic [AW-1:0] REG_ZERO = {AW{1'b0}};

endpackage

// File: rtl/rr_arb2.sv
// Two-input arbiter: round-robin on conflict when i_rr is set, otherwise req0 has fixed priority.
module rr_arb2 (
    input  logic       clk,
    input  logic       rstn,
    input  logic       i_en,
    input  logic       i_rr,
    input  logic [1:0] i_valid,
    output logic [1:0] o_grant
);

    logic       r_last_grant;
    logic [1:0] w_grant;

    // Same-cycle one-hot grant; on conflict favour the requester that did not win last.
    always_comb begin
        w_grant = 2'b00;
        if (i_en) begin
            case (i_valid)
                2'b01:   w_grant = 2'b01;
                2'b10:   w_grant = 2'b10;
                2'b11: begin
                    if (i_rr && (r_last_grant == 1'b0)) begin
                        w_grant = 2'b10;
                    end else begin
                        w_grant = 2'b01;
                    end
                end
                default: w_grant = 2'b00;
            endcase
        end else begin
            w_grant = 2'b00;
        end
    end

    // Remember the most recent winner; hold when nothing is granted.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_last_grant <= 1'b1;
        end else if (w_grant != 2'b00) begin
            r_last_grant <= w_grant[1];
        end else begin
            r_last_grant <= r_last_grant;
        end
    end

    assign o_grant = w_grant;

endmodule

// File: rtl/rf_wport_arbiter.sv
// Owns the register-file write port: arbitrates two write-back requesters and
// runs a clear sequence that zeroes r1..NREG-1 after reset and on request.
module rf_wport_arbiter #(
    parameter int AW           = rf_pkg::AW,
    parameter int DW           = rf_pkg::DW,
    parameter int NREG         = rf_pkg::NREG,
    parameter int CLR_ON_RESET = 1,
    parameter int RR           = 1
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          clear_req,
    output logic          busy,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_data,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_data,
    output logic          rf_we,
    output logic [AW-1:0] rf_wa,
    output logic [DW-1:0] rf_wd
);

    import rf_pkg::*;

    localparam logic [AW-1:0] CNT_FIRST = AW'(1);
    localparam logic [AW-1:0] CNT_LAST  = AW'(NREG - 1);
    localparam logic [AW-1:0] ADDR_ZERO = AW'(REG_ZERO);
    localparam state_e        RST_STATE = (CLR_ON_RESET != 0) ? CLEAR : RUN;

    state_e        r_state;
    state_e        w_state_nxt;
    logic [AW-1:0] r_clr_cnt;
    logic [AW-1:0] w_clr_cnt_nxt;
    logic [1:0]    w_grant;
    logic          w_run;
    logic          w_clr_last;

    assign w_run      = (r_state == RUN);
    assign w_clr_last = (r_clr_cnt == CNT_LAST);

    rr_arb2 u_arb (
        .clk     (clk),
        .rstn    (rstn),
        .i_en    (w_run),
        .i_rr    ((RR != 0) ? 1'b1 : 1'b0),
        .i_valid ({req1_valid, req0_valid}),
        .o_grant (w_grant)
    );

    // State and clear-address registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= RST_STATE;
            r_clr_cnt <= CNT_FIRST;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= w_clr_cnt_nxt;
        end
    end

    // Next state: CLEAR sweeps 1..NREG-1 once; RUN enters CLEAR the cycle after clear_req.
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        case (r_state)
            CLEAR: begin
                if (w_clr_last) begin
                    w_state_nxt   = RUN;
                    w_clr_cnt_nxt = CNT_FIRST;
                end else begin
                    w_clr_cnt_nxt = r_clr_cnt + AW'(1);
                end
            end
            RUN: begin
                if (clear_req) begin
                    w_state_nxt = CLEAR;
                end else begin
                    w_state_nxt = RUN;
                end
            end
            default: begin
                w_state_nxt   = RST_STATE;
                w_clr_cnt_nxt = CNT_FIRST;
            end
        endcase
    end

    // Write-port mux; outputs are forced quiet while reset is held.
    always_comb begin
        busy       = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rf_we      = 1'b0;
        rf_wa      = {AW{1'b0}};
        rf_wd      = {DW{1'b0}};
        if (!rstn) begin
            busy = (CLR_ON_RESET != 0);
        end else begin
            case (r_state)
                CLEAR: begin
                    busy  = 1'b1;
                    rf_we = 1'b1;
                    rf_wa = r_clr_cnt;
                end
                RUN: begin
                    req0_ready = w_grant[0];
                    req1_ready = w_grant[1];
                    // Writes to r0 are accepted but never reach the RF.
                    if (w_grant[0]) begin
                        rf_we = (req0_addr != ADDR_ZERO);
                        rf_wa = req0_addr;
                        rf_wd = req0_data;
                    end else if (w_grant[1]) begin
                        rf_we = (req1_addr != ADDR_ZERO);
                        rf_wa = req1_addr;
                        rf_wd = req1_data;
                    end else begin
                        rf_we = 1'b0;
                    end
                end
                default: begin
                    busy = 1'b0;
                end
            endcase
        end
    end

endmodule
